mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares one single-ported, fixed-latency unified memory between the CPU's instruction-fetch port and its load/store port. It sits between the CPU core and the memory macro. It serialises accesses, one transaction outstanding at a time, and drives a stall signal so the core can freeze while its access is pending.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency memory between an instruction-fetch
// port and a load/store port. Only one transaction is outstanding at a time.
// Arbitration is round-robin on the port granted last.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   instr_req/addr    : fetch request (held until instr_ack) and its address
//   instr_rdata/ack   : fetched word, one-cycle completion pulse
//   data_req/write    : load/store request, byte enables (0 = load)
//   data_addr/in      : load/store address, store data
//   data_out/ack      : load data, one-cycle completion pulse
//   mem_en/we/addr/wdata : memory strobe (one cycle per transaction) and command
//   mem_rdata         : memory read data, valid MEM_LAT cycles after mem_en
//   stall             : core freeze while either request is pending
module mem_port_arbiter #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_ack,
  input  logic        data_req,
  input  logic [3:0]  data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        data_ack,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // The counter is loaded in ISSUE and counts down through WAIT; the cycle
  // in which it reads zero is the cycle mem_rdata is valid.
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  logic [1:0]  state_reg, state_next;
  logic        last_grant_reg;   // 0 = instruction, 1 = data
  logic        grant_reg;        // winner of the transaction in flight
  logic [3:0]  cnt_reg;
  logic [31:0] addr_reg;
  logic [3:0]  we_reg;
  logic [31:0] wdata_reg;
  logic [31:0] instr_rdata_reg;
  logic [31:0] data_out_reg;
  logic        win_data;
  logic        capture;

  // A lone requester wins; on a tie the port not granted last wins.
  assign win_data = data_req & (~instr_req | ~last_grant_reg);

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (instr_req | data_req) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        // Read data always arrives at least one cycle after the strobe,
        // so even MEM_LAT=1 passes through one WAIT cycle.
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_reg == 4'd0) begin
          capture    = 1'b1;
          state_next = S_DONE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      last_grant_reg  <= 1'b0;
      grant_reg       <= 1'b0;
      cnt_reg         <= 4'd0;
      addr_reg        <= 32'd0;
      we_reg          <= 4'd0;
      wdata_reg       <= 32'd0;
      instr_rdata_reg <= 32'd0;
      data_out_reg    <= 32'd0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (instr_req | data_req) begin
            grant_reg <= win_data;
            addr_reg  <= win_data ? data_addr : instr_addr;
            we_reg    <= win_data ? data_write : 4'd0;
            // Fetches carry no write data; keep the last store's word.
            if (win_data) wdata_reg <= data_in;
          end
        end
        S_ISSUE: begin
          cnt_reg <= LAT_M1;
        end
        S_WAIT: begin
          if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
        end
        default: begin
          last_grant_reg <= grant_reg;
        end
      endcase
      if (capture) begin
        if (grant_reg) data_out_reg    <= mem_rdata;
        else           instr_rdata_reg <= mem_rdata;
      end
    end
  end

  assign mem_en      = (state_reg == S_ISSUE);
  assign mem_we      = (state_reg == S_ISSUE) ? we_reg : 4'd0;
  assign mem_addr    = addr_reg;
  assign mem_wdata   = wdata_reg;
  assign instr_ack   = (state_reg == S_DONE) & ~grant_reg;
  assign data_ack    = (state_reg == S_DONE) & grant_reg;
  assign instr_rdata = instr_rdata_reg;
  assign data_out    = data_out_reg;
  assign stall       = (instr_req & ~instr_ack) | (data_req & ~data_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model (free-at cycle,
// round-robin winner, reference memory contents).
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        instr_req, instr_ack, data_req, data_ack, mem_en, stall;
  logic [31:0] instr_addr, instr_rdata, data_addr, data_in, data_out;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  data_write, mem_we;

  logic        l1_instr_req, l1_instr_ack, l1_data_req, l1_data_ack, l1_mem_en, l1_stall;
  logic [31:0] l1_instr_addr, l1_instr_rdata, l1_data_addr, l1_data_in, l1_data_out;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
  logic [3:0]  l1_data_write, l1_mem_we;

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_rdata(instr_rdata), .instr_ack(instr_ack),
    .data_req(data_req), .data_write(data_write), .data_addr(data_addr), .data_in(data_in),
    .data_out(data_out), .data_ack(data_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  mem_port_arbiter #(.MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst),
    .instr_req(l1_instr_req), .instr_addr(l1_instr_addr), .instr_rdata(l1_instr_rdata),
    .instr_ack(l1_instr_ack),
    .data_req(l1_data_req), .data_write(l1_data_write), .data_addr(l1_data_addr),
    .data_in(l1_data_in), .data_out(l1_data_out), .data_ack(l1_data_ack),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .stall(l1_stall)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory macro model (read-first, fixed latency) --------
  logic [31:0] mem_arr [256];
  bit          written [256];
  logic        resp_valid = 1'b0;
  int          resp_cyc = 0;
  logic [31:0] resp_data = 32'd0;

  function automatic logic [31:0] init_word(input int idx);
    if (idx == 64) return 32'hDEADBEEF;
    return 32'h9E3779B9 * idx + 32'h0BADF00D;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mem_word(input logic [7:0] idx);
    return written[idx] ? mem_arr[idx] : init_word(int'(idx));
  endfunction

  always @(posedge clk) begin
    if (mem_en) begin
      resp_valid <= 1'b1;
      resp_cyc   <= cyc + LAT;
      resp_data  <= mem_word(mem_addr[9:2]);
      if (mem_we != 4'd0) begin
        mem_arr[mem_addr[9:2]] <= merge(mem_word(mem_addr[9:2]), mem_wdata, mem_we);
        written[mem_addr[9:2]] <= 1'b1;
      end
    end
  end

  // Outside the response cycle the read bus carries junk.
  always @(negedge clk) mem_rdata <= (resp_valid && cyc == resp_cyc) ? resp_data : $urandom();

  logic [31:0] ref_mem [256];

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    return {26'd0, 4'($urandom()), 2'b00};
  endfunction

  // ---------------- scenarios ----------------------------------------------
  task automatic test_reset();
    step(); rst = 1'b1; step(); #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, instr_ack, data_ack, instr_rdata, data_out, stall} !== '0)
      begin errors++; $display("FAIL reset_outputs got en=%b we=%h addr=%h wd=%h ia=%b da=%b ir=%h do=%h st=%b want all 0",
        mem_en, mem_we, mem_addr, mem_wdata, instr_ack, data_ack, instr_rdata, data_out, stall); end
    checks++;
    if ({l1_mem_en, l1_mem_we, l1_mem_addr, l1_mem_wdata, l1_instr_ack, l1_data_ack, l1_instr_rdata, l1_data_out, l1_stall} !== '0)
      begin errors++; $display("FAIL reset_outputs_lat1 got nonzero output want all 0"); end
    step(); rst = 1'b0;
    $display("reset: checked");
  endtask

  task automatic test_single_fetch();
    step(); instr_req = 1'b1; instr_addr = 32'h100; #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin step(); #1; end
      checks++; if (mem_en !== (k == 1)) begin errors++; $display("FAIL fetch_mem_en k=%0d got %b want %b", k, mem_en, k == 1); end
      checks++; if (instr_ack !== (k == 4)) begin errors++; $display("FAIL fetch_ack k=%0d got %b want %b", k, instr_ack, k == 4); end
      checks++; if (stall !== (k < 4)) begin errors++; $display("FAIL fetch_stall k=%0d got %b want %b", k, stall, k < 4); end
      checks++; if (data_ack !== 1'b0) begin errors++; $display("FAIL fetch_data_ack k=%0d got %b want 0", k, data_ack); end
      if (k == 1) begin
        checks++; if (mem_addr !== 32'h100 || mem_we !== 4'd0)
          begin errors++; $display("FAIL fetch_issue got addr=%h we=%h want 00000100/0", mem_addr, mem_we); end
      end
      if (k == 4) begin
        checks++; if (instr_rdata !== 32'hDEADBEEF)
          begin errors++; $display("FAIL fetch_rdata got %h want deadbeef", instr_rdata); end
      end
    end
    step(); instr_req = 1'b0; #1;
    checks++; if (mem_en !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL fetch_after got en=%b st=%b want 0/0", mem_en, stall); end
    $display("single_fetch: addr=00000100 rdata=%h", instr_rdata);
  endtask

  task automatic test_store();
    step(); data_req = 1'b1; data_write = 4'b0011; data_addr = 32'h20; data_in = 32'h0000ABCD; #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin step(); #1; end
      checks++; if (mem_en !== (k == 1)) begin errors++; $display("FAIL store_mem_en k=%0d got %b want %b", k, mem_en, k == 1); end
      checks++; if (mem_we !== ((k == 1) ? 4'b0011 : 4'b0000)) begin errors++; $display("FAIL store_mem_we k=%0d got %h", k, mem_we); end
      checks++; if (data_ack !== (k == 4)) begin errors++; $display("FAIL store_ack k=%0d got %b want %b", k, data_ack, k == 4); end
      checks++; if (instr_ack !== 1'b0) begin errors++; $display("FAIL store_instr_ack k=%0d got %b want 0", k, instr_ack); end
      if (k == 1) begin
        checks++; if (mem_wdata !== 32'h0000ABCD || mem_addr !== 32'h20)
          begin errors++; $display("FAIL store_issue got wd=%h addr=%h want 0000abcd/00000020", mem_wdata, mem_addr); end
      end
    end
    ref_mem[8] = merge(ref_mem[8], 32'h0000ABCD, 4'b0011);
    step(); data_req = 1'b0; data_write = 4'd0; step();
    $display("store: addr=00000020 wdata=0000abcd we=3");
  endtask

  task automatic test_tie_from_reset();
    step(); rst = 1'b1;
    instr_req = 1'b1; instr_addr = 32'h40; data_req = 1'b1; data_write = 4'd0; data_addr = 32'h80;
    step(); rst = 1'b0; #1;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) begin step(); #1; end
      checks++; if (data_ack !== (k == 4 || k == 14)) begin errors++; $display("FAIL tie_data_ack k=%0d got %b", k, data_ack); end
      checks++; if (instr_ack !== (k == 9)) begin errors++; $display("FAIL tie_instr_ack k=%0d got %b", k, instr_ack); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL tie_stall k=%0d got %b want 1", k, stall); end
      checks++; if (mem_en !== (k == 1 || k == 6 || k == 11)) begin errors++; $display("FAIL tie_mem_en k=%0d got %b", k, mem_en); end
      if (k == 1 || k == 11) begin
        checks++; if (mem_addr !== 32'h80) begin errors++; $display("FAIL tie_grant_data k=%0d got %h want 00000080", k, mem_addr); end
      end
      if (k == 6) begin
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL tie_grant_instr got %h want 00000040", mem_addr); end
      end
      if (data_ack === 1'b1) begin
        checks++; if (data_out !== ref_mem[32]) begin errors++; $display("FAIL tie_data_out got %h want %h", data_out, ref_mem[32]); end
      end
      if (instr_ack === 1'b1) begin
        checks++; if (instr_rdata !== ref_mem[16]) begin errors++; $display("FAIL tie_instr_rdata got %h want %h", instr_rdata, ref_mem[16]); end
      end
    end
    step(); instr_req = 1'b0; data_req = 1'b0; step();
    $display("tie_from_reset: acks data@4 instr@9 data@14");
  endtask

  task automatic test_reset_mid_wait();
    step(); data_req = 1'b1; data_write = 4'd0; data_addr = 32'h44; #1;
    step(); #1;
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL midrst_issue got %b want 1", mem_en); end
    step(); rst = 1'b1; #1;
    step(); rst = 1'b0; data_req = 1'b0; #1;
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, instr_ack, data_ack, instr_rdata, data_out, stall} !== '0)
      begin errors++; $display("FAIL midrst_outputs got en=%b we=%h addr=%h wd=%h ia=%b da=%b ir=%h do=%h want all 0",
        mem_en, mem_we, mem_addr, mem_wdata, instr_ack, data_ack, instr_rdata, data_out); end
    for (int k = 0; k < 6; k++) begin
      step(); #1;
      checks++; if (data_ack !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL midrst_no_ack k=%0d got da=%b en=%b", k, data_ack, mem_en); end
    end
    step(); instr_req = 1'b1; instr_addr = 32'h48; data_req = 1'b1; data_addr = 32'h4C; #1;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) begin step(); if (j == 5) data_req = 1'b0; #1; end
      checks++; if (data_ack !== (j == 4)) begin errors++; $display("FAIL midrst_tie_data j=%0d got %b", j, data_ack); end
      checks++; if (instr_ack !== (j == 9)) begin errors++; $display("FAIL midrst_tie_instr j=%0d got %b", j, instr_ack); end
      if (j == 4) begin
        checks++; if (data_out !== ref_mem[19]) begin errors++; $display("FAIL midrst_data_out got %h want %h", data_out, ref_mem[19]); end
      end
      if (j == 9) begin
        checks++; if (instr_rdata !== ref_mem[18]) begin errors++; $display("FAIL midrst_instr_rdata got %h want %h", instr_rdata, ref_mem[18]); end
      end
    end
    step(); instr_req = 1'b0; step();
    $display("reset_mid_wait: aborted load dropped, data won next tie");
  endtask

  task automatic test_back_to_back();
    step(); instr_req = 1'b1; instr_addr = 32'h104; #1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin step(); #1; end
      checks++; if (mem_en !== (k == 1 || k == 6)) begin errors++; $display("FAIL b2b_mem_en k=%0d got %b", k, mem_en); end
      checks++; if (instr_ack !== (k == 4 || k == 9)) begin errors++; $display("FAIL b2b_ack k=%0d got %b", k, instr_ack); end
      if (k == 9) begin
        checks++; if (instr_rdata !== ref_mem[65]) begin errors++; $display("FAIL b2b_rdata got %h want %h", instr_rdata, ref_mem[65]); end
      end
    end
    step(); instr_req = 1'b0; step();
    $display("back_to_back: second fetch issued at k=6, acked at k=9");
  endtask

  task automatic test_lat1();
    step(); l1_data_req = 1'b1; l1_data_write = 4'd0; l1_data_addr = 32'h30; l1_mem_rdata = $urandom(); #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin step(); l1_mem_rdata = (k == 2) ? 32'hCAFEF00D : $urandom(); #1; end
      checks++; if (l1_mem_en !== (k == 1)) begin errors++; $display("FAIL lat1_mem_en k=%0d got %b", k, l1_mem_en); end
      checks++; if (l1_data_ack !== (k == 3)) begin errors++; $display("FAIL lat1_ack k=%0d got %b", k, l1_data_ack); end
      checks++; if (l1_stall !== (k < 3)) begin errors++; $display("FAIL lat1_stall k=%0d got %b", k, l1_stall); end
    end
    checks++; if (l1_data_out !== 32'hCAFEF00D) begin errors++; $display("FAIL lat1_data_out got %h want cafef00d", l1_data_out); end
    step(); l1_data_req = 1'b0; step();
    $display("lat1: load acked at cycle 3 data=%h", l1_data_out);
  endtask

  task automatic test_random(input int ncyc);
    int          c, free_cyc, issue_cyc, ack_cyc, ntx;
    bit          last_data, win_data, i_acked, d_acked, e_ien, e_iack, e_dack, e_stall, i_busy, d_busy;
    logic [31:0] e_addr, e_wdata, e_rd, e_irdata, e_drdata;
    logic [3:0]  e_we;
    step(); rst = 1'b1; instr_req = 1'b0; data_req = 1'b0;
    step(); rst = 1'b0;
    free_cyc = cyc; issue_cyc = -1; ack_cyc = -1; last_data = 1'b0; win_data = 1'b0;
    i_acked = 1'b0; d_acked = 1'b0; e_irdata = 32'd0; e_drdata = 32'd0; ntx = 0;
    e_addr = 32'd0; e_we = 4'd0; e_wdata = 32'd0; e_rd = 32'd0;
    for (int n = 0; n < ncyc; n++) begin
      if (n > 0) step();
      c = cyc;
      i_busy = (c <= ack_cyc) && !win_data;
      d_busy = (c <= ack_cyc) && win_data;
      if (!instr_req) begin
        if ($urandom_range(2) == 0) begin instr_req = 1'b1; instr_addr = rand_addr(); end
      end else if (i_acked) begin
        case ($urandom_range(2))
          0: instr_req = 1'b0;
          1: instr_addr = rand_addr();
          default: ;
        endcase
      end else if (!i_busy && $urandom_range(3) == 0) instr_addr = rand_addr();
      if (!data_req || d_acked || (!d_busy && $urandom_range(3) == 0)) begin
        if (!data_req && $urandom_range(2) != 0) begin
        end else if (data_req && d_acked && $urandom_range(2) == 0) begin
          data_req = 1'b0;
        end else begin
          data_req = 1'b1; data_addr = rand_addr(); data_in = $urandom();
          data_write = ($urandom_range(1) == 1) ? 4'($urandom()) : 4'd0;
        end
      end
      // Reference model: the arbiter accepts a new transaction when free,
      // and each one occupies exactly LAT+3 cycles.
      if (c == free_cyc) begin
        if (instr_req || data_req) begin
          win_data  = data_req && (!instr_req || !last_data);
          last_data = win_data;
          issue_cyc = c + 1; ack_cyc = c + 2 + LAT; free_cyc = c + 3 + LAT;
          e_addr  = win_data ? data_addr : instr_addr;
          e_we    = win_data ? data_write : 4'd0;
          e_wdata = data_in;
          e_rd    = ref_mem[e_addr[9:2]];
          if (win_data) ref_mem[e_addr[9:2]] = merge(e_rd, data_in, data_write);
          ntx++;
        end else free_cyc = c + 1;
      end
      #1;
      e_ien  = (c == issue_cyc);
      e_iack = (c == ack_cyc) && !win_data;
      e_dack = (c == ack_cyc) && win_data;
      if (e_iack) e_irdata = e_rd;
      if (e_dack) e_drdata = e_rd;
      e_stall = (instr_req && !e_iack) || (data_req && !e_dack);
      checks++; if (mem_en !== e_ien) begin errors++; $display("FAIL rnd_mem_en cyc=%0d got %b want %b", c, mem_en, e_ien); end
      checks++; if (mem_we !== (e_ien ? e_we : 4'd0)) begin errors++; $display("FAIL rnd_mem_we cyc=%0d got %h want %h", c, mem_we, e_ien ? e_we : 4'd0); end
      if (e_ien) begin
        checks++; if (mem_addr !== e_addr) begin errors++; $display("FAIL rnd_mem_addr cyc=%0d got %h want %h", c, mem_addr, e_addr); end
        if (win_data) begin
          checks++; if (mem_wdata !== e_wdata) begin errors++; $display("FAIL rnd_mem_wdata cyc=%0d got %h want %h", c, mem_wdata, e_wdata); end
        end
      end
      checks++; if (instr_ack !== e_iack) begin errors++; $display("FAIL rnd_instr_ack cyc=%0d got %b want %b", c, instr_ack, e_iack); end
      checks++; if (data_ack !== e_dack) begin errors++; $display("FAIL rnd_data_ack cyc=%0d got %b want %b", c, data_ack, e_dack); end
      checks++; if (instr_rdata !== e_irdata) begin errors++; $display("FAIL rnd_instr_rdata cyc=%0d got %h want %h", c, instr_rdata, e_irdata); end
      checks++; if (data_out !== e_drdata) begin errors++; $display("FAIL rnd_data_out cyc=%0d got %h want %h", c, data_out, e_drdata); end
      checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got %b want %b", c, stall, e_stall); end
      i_acked = e_iack;
      d_acked = e_dack;
    end
    $display("random: %0d cycles, %0d transactions granted", ncyc, ntx);
  endtask

  initial begin
    rst = 1'b1;
    instr_req = 1'b0; instr_addr = 32'd0; data_req = 1'b0; data_write = 4'd0;
    data_addr = 32'd0; data_in = 32'd0;
    l1_instr_req = 1'b0; l1_instr_addr = 32'd0; l1_data_req = 1'b0; l1_data_write = 4'd0;
    l1_data_addr = 32'd0; l1_data_in = 32'd0; l1_mem_rdata = 32'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_single_fetch();
    test_store();
    test_tie_from_reset();
    test_reset_mid_wait();
    test_back_to_back();
    test_lat1();
    test_random(1500);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
